// File: rtl/ddfs_cordic_pipe.sv
// ddfs_cordic_pipe
//
// Pipelined direct digital frequency synthesiser. A programmable phase accumulator
// feeds an unrolled CORDIC rotator. One sine/cosine pair can be launched per clock.
// Outputs are signed fixed point: 1 sign, 3 integer and FRAC_W fraction bits.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset_n    in   synchronous active-low reset
//   en         in   advance accumulator and launch one sample
//   ftw_in     in   frequency tuning word (unsigned, PHASE_W bits)
//   ftw_load   in   capture ftw_in into the tuning-word register
//   phase_off  in   phase offset added to every sample (mod 2^PHASE_W)
//   sync_clr   in   force the accumulator to zero
//   sin_out    out  signed sine sample (DATA_W bits)
//   cos_out    out  signed cosine sample (DATA_W bits)
//   out_valid  out  sin_out/cos_out carry a new sample this cycle
//
// Latency: a sample launched by en appears STAGES+2 clocks later.
//
// Build option: define DDFS_GAIN_COMP_EN to pre-scale the CORDIC start vector by
// 1/K so the output amplitude is 1.0. Without it the amplitude is K (about 1.647)
// and downstream logic has to scale.

module ddfs_cordic_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned FRAC_W  = 28,
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned STAGES  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic [PHASE_W-1:0] ftw_in,
    input  logic               ftw_load,
    input  logic [PHASE_W-1:0] phase_off,
    input  logic               sync_clr,
    output logic [DATA_W-1:0]  sin_out,
    output logic [DATA_W-1:0]  cos_out,
    output logic               out_valid
);

    localparam int unsigned XW = DATA_W + 2;   // x/y carry two guard bits
    localparam int unsigned ZW = PHASE_W + 1;  // signed residual angle
    localparam real Pi = 3.14159265358979323846;

    // Elaboration-time helpers; only ever evaluated into constants.
    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) begin
            for (int k = 0; k < e; k++) r = r * 2.0;
        end else begin
            for (int k = 0; k < -e; k++) r = r / 2.0;
        end
        return r;
    endfunction

    // atan(2^-i) in radians; Taylor series converges quickly for i >= 1.
    function automatic real atan_pow2(input int i);
        real x, term, sum;
        if (i == 0) return Pi / 4.0;
        x    = pow2(-i);
        term = x;
        sum  = 0.0;
        for (int n = 0; n < 40; n++) begin
            sum  = sum + term / real'(2 * n + 1);
            term = -term * x * x;
        end
        return sum;
    endfunction

    // Binary-angle constant: atan(2^-i)/(2*pi) * 2^PHASE_W, rounded to nearest.
    function automatic logic signed [ZW-1:0] atan_const(input int i);
        return ZW'(longint'(atan_pow2(i) / (2.0 * Pi) * pow2(int'(PHASE_W))));
    endfunction

`ifdef DDFS_GAIN_COMP_EN
    function automatic real sqrt_r(input real a);
        real g;
        g = a;
        for (int k = 0; k < 40; k++) g = 0.5 * (g + a / g);
        return g;
    endfunction

    function automatic real cordic_gain(input int n);
        real k;
        k = 1.0;
        for (int i = 0; i < n; i++) k = k * sqrt_r(1.0 + pow2(-2 * i));
        return k;
    endfunction

    localparam real KGain = cordic_gain(int'(STAGES));
    localparam logic signed [XW-1:0] XInit =
        XW'(longint'(pow2(int'(FRAC_W)) / KGain));
`else
    localparam logic signed [XW-1:0] XInit =
        {{(XW - FRAC_W - 1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
`endif

    // ------------------------------------------------------------------
    // Phase accumulator
    // ------------------------------------------------------------------
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] ftw_q;
    logic [PHASE_W-1:0] phase;

    always_comb begin
        phase = acc_q + phase_off;  // sampled with the pre-update accumulator
        acc_d = acc_q;
        if (sync_clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ftw_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q <= '0;
            ftw_q <= '0;
        end else begin
            acc_q <= acc_d;
            // Same-cycle accumulate already used the old word via acc_d.
            if (ftw_load) ftw_q <= ftw_in;
        end
    end

    // ------------------------------------------------------------------
    // CORDIC pipeline: index 0 is the launch stage, 1..STAGES the iterations
    // ------------------------------------------------------------------
    logic signed [XW-1:0] x_q [0:STAGES];
    logic signed [XW-1:0] y_q [0:STAGES];
    logic signed [ZW-1:0] z_q [0:STAGES];
    logic [1:0]           q_q [0:STAGES];
    logic                 v_q [0:STAGES];

    logic signed [XW-1:0] x_d [1:STAGES];
    logic signed [XW-1:0] y_d [1:STAGES];
    logic signed [ZW-1:0] z_d [1:STAGES];

    for (genvar i = 1; i <= STAGES; i++) begin : g_iter
        localparam logic signed [ZW-1:0] AtanI = atan_const(i - 1);
        logic z_neg;

        assign z_neg  = z_q[i-1][ZW-1];
        assign x_d[i] = z_neg ? x_q[i-1] + (y_q[i-1] >>> (i - 1))
                              : x_q[i-1] - (y_q[i-1] >>> (i - 1));
        assign y_d[i] = z_neg ? y_q[i-1] - (x_q[i-1] >>> (i - 1))
                              : y_q[i-1] + (x_q[i-1] >>> (i - 1));
        assign z_d[i] = z_neg ? z_q[i-1] + AtanI : z_q[i-1] - AtanI;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i <= int'(STAGES); i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
                z_q[i] <= '0;
                q_q[i] <= '0;
                v_q[i] <= 1'b0;
            end
        end else begin
            // Launch stage: quadrant split, residual angle lies in [0, 90 deg).
            x_q[0] <= XInit;
            y_q[0] <= '0;
            z_q[0] <= {3'b000, phase[PHASE_W-3:0]};
            q_q[0] <= phase[PHASE_W-1 -: 2];
            v_q[0] <= en;
            for (int i = 1; i <= int'(STAGES); i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
                z_q[i] <= z_d[i];
                q_q[i] <= q_q[i-1];
                v_q[i] <= v_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Quadrant fix-up and output register
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] c_t, s_t, cos_fix, sin_fix;

    always_comb begin
        // Truncating before negation gives the same DATA_W bits as after.
        c_t     = x_q[STAGES][DATA_W-1:0];
        s_t     = y_q[STAGES][DATA_W-1:0];
        cos_fix = c_t;
        sin_fix = s_t;
        unique case (q_q[STAGES])
            2'd0: begin cos_fix = c_t;  sin_fix = s_t;  end
            2'd1: begin cos_fix = -s_t; sin_fix = c_t;  end
            2'd2: begin cos_fix = -c_t; sin_fix = -s_t; end
            2'd3: begin cos_fix = s_t;  sin_fix = -c_t; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cos_out   <= '0;
            sin_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v_q[STAGES];
            if (v_q[STAGES]) begin
                cos_out <= cos_fix;
                sin_out <= sin_fix;
            end
        end
    end

endmodule
